// File: rtl/spi_px_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_px_master
// Brief    : Mode-0 SPI initiator. Sends one DATA_BITS-wide pixel word MSB
//            first per chip-select window and captures the word shifted back.
// Revision : 1.0 - initial release
// ============================================================================
module spi_px_master #(
  parameter int DATA_BITS = 24,
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_GAP    = 2
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 busy_o,
  output logic                 spi_sck_o,
  output logic                 spi_sdo_o,
  input  logic                 spi_sdi_i,
  output logic                 spi_cs_o
);

  localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int c_CNT_MAX = (CS_SETUP > CS_HOLD) ?
                             ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                             ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

  localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST   = c_BIT_W'(DATA_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;      // shared by SETUP, HOLD and GAP windows
  logic [c_DIV_W-1:0]   r_div;
  logic [c_BIT_W-1:0]   r_bit;
  logic [DATA_BITS-1:0] r_tx;
  logic [DATA_BITS-1:0] r_rx;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_tx_ready;
  logic                 r_sck;
  logic                 r_sdo;
  logic                 r_cs;

  // Frame sequencer: chip-select framing, SCK generation and both shifters
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_div      <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b1;
      r_sck      <= 1'b0;
      r_sdo      <= 1'b0;
      r_cs       <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx_valid_i && r_tx_ready) begin
            r_tx       <= tx_data_i;
            r_sdo      <= tx_data_i[DATA_BITS-1];
            r_cs       <= 1'b0;
            r_tx_ready <= 1'b0;
            r_cnt      <= '0;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == c_SETUP_LAST) begin
            r_cnt   <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (r_div == c_DIV_LAST) begin
            r_div <= '0;
            r_sck <= ~r_sck;
            if (!r_sck) begin
              // Rising edge: the slave has held SDI stable since the last fall
              r_rx <= {r_rx[DATA_BITS-2:0], spi_sdi_i};
            end else if (r_bit == c_BIT_LAST) begin
              // Final falling edge: SDO keeps the last bit through HOLD
              r_cnt   <= '0;
              r_state <= ST_HOLD;
            end else begin
              r_tx  <= {r_tx[DATA_BITS-2:0], 1'b0};
              r_sdo <= r_tx[DATA_BITS-2];
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_cnt == c_HOLD_LAST) begin
            r_cs       <= 1'b1;
            r_sdo      <= 1'b0;
            r_rx_data  <= r_rx;
            r_rx_valid <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_tx_ready <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready_o = r_tx_ready;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign busy_o     = (r_state != ST_IDLE);
  assign spi_sck_o  = r_sck;
  assign spi_sdo_o  = r_sdo;
  assign spi_cs_o   = r_cs;

endmodule
`default_nettype wire
